reg_bcd_display: RTL and testbench

Reader side of the 14-bit data register: samples the register's output on request and converts it sequentially from binary to four BCD digits with a shift-add-3 (double-dabble) engine. It then drives a time-multiplexed, active-low 4-digit seven-segment display. It sits between the data register output and the board display pins.

---
 rtl/reg_bcd_display_if.sv | 23 ++
 rtl/reg_bcd_display.sv | 145 ++++++++++++++
 tb/tb_reg_bcd_display.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/reg_bcd_display_if.sv
// Bus between the data register reader and the 4-digit seven-segment display driver.
// The master side requests conversions and the slave (reg_bcd_display) returns BCD and display pins.
interface reg_bcd_display_if;
   logic        i_load;
   logic [13:0] i_data_in;
   logic        o_busy;
   logic        o_valid;
   logic        o_overflow;
   logic [15:0] o_bcd;
   logic [3:0]  o_an;
   logic [6:0]  o_seg;
   logic        o_dp;

   modport master (
      output i_load, i_data_in,
      input  o_busy, o_valid, o_overflow, o_bcd, o_an, o_seg, o_dp
   );

   modport slave (
      input  i_load, i_data_in,
      output o_busy, o_valid, o_overflow, o_bcd, o_an, o_seg, o_dp
   );
endinterface

// File: rtl/reg_bcd_display.sv
// Samples a 14-bit register value, converts it to four BCD digits with a shift-add-3 engine,
// and drives a multiplexed active-low 4-digit seven-segment display from the committed result.
module reg_bcd_display #(
   parameter int REFRESH_DIV = 50000,
   parameter int BLANK_LZ    = 1
) (
   input logic clk,
   input logic rst,
   reg_bcd_display_if.slave bus
);

   localparam int DIV_W = $clog2(REFRESH_DIV);
   localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(REFRESH_DIV - 1);

   typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

   state_t      r_state, w_nextState;
   logic [13:0] r_shift;
   logic [15:0] r_acc, w_adj;
   logic [3:0]  r_iter;
   logic        r_ovfPending;
   logic [15:0] r_bcd;
   logic        r_overflow, r_valid, w_busy;

   logic [DIV_W-1:0] r_div;
   logic [1:0]       r_digitIdx, w_nextIdx;
   logic [3:0]       r_an, w_an, w_digit;
   logic [6:0]       r_seg, w_seg, w_glyph;
   logic             w_blank;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_nextState;
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE:    if (bus.i_load) w_nextState = CONV;
         CONV:    if (r_iter == 4'd13) w_nextState = DONE;
         DONE:    w_nextState = IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   always_comb begin
      w_busy = (r_state != IDLE);
   end

   always_comb begin
      w_adj = r_acc;
      for (int n = 0; n < 4; n++) begin
         if (r_acc[4*n +: 4] >= 4'd5) w_adj[4*n +: 4] = r_acc[4*n +: 4] + 4'd3;
      end
   end

   // Out-of-range values still run the 14 iterations; the flag overrides the result at commit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_shift      <= '0;
         r_acc        <= '0;
         r_iter       <= '0;
         r_ovfPending <= 1'b0;
         r_bcd        <= '0;
         r_overflow   <= 1'b0;
         r_valid      <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         case (r_state)
            IDLE: if (bus.i_load) begin
               r_shift      <= bus.i_data_in;
               r_acc        <= '0;
               r_iter       <= '0;
               r_ovfPending <= (bus.i_data_in > 14'd9999);
            end
            CONV: begin
               {r_acc, r_shift} <= {w_adj, r_shift} << 1;
               r_iter           <= r_iter + 4'd1;
            end
            DONE: begin
               r_bcd      <= r_ovfPending ? 16'h9999 : r_acc;
               r_overflow <= r_ovfPending;
               r_valid    <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      w_nextIdx = r_digitIdx + 2'd1;
      w_an      = ~(4'b0001 << w_nextIdx);
      w_digit   = r_bcd[3:0];
      w_blank   = 1'b0;
      case (w_nextIdx)
         2'd0: begin w_digit = r_bcd[3:0];   w_blank = 1'b0;                end
         2'd1: begin w_digit = r_bcd[7:4];   w_blank = (r_bcd[15:4] == '0);  end
         2'd2: begin w_digit = r_bcd[11:8];  w_blank = (r_bcd[15:8] == '0);  end
         2'd3: begin w_digit = r_bcd[15:12]; w_blank = (r_bcd[15:12] == '0); end
         default: ;
      endcase
      case (w_digit)
         4'd0:    w_glyph = 7'b1000000;
         4'd1:    w_glyph = 7'b1111001;
         4'd2:    w_glyph = 7'b0100100;
         4'd3:    w_glyph = 7'b0110000;
         4'd4:    w_glyph = 7'b0011001;
         4'd5:    w_glyph = 7'b0010010;
         4'd6:    w_glyph = 7'b0000010;
         4'd7:    w_glyph = 7'b1111000;
         4'd8:    w_glyph = 7'b0000000;
         4'd9:    w_glyph = 7'b0010000;
         default: w_glyph = 7'b1111111;
      endcase
      if (r_overflow)                      w_seg = 7'b0111111;
      else if ((BLANK_LZ != 0) && w_blank) w_seg = 7'b1111111;
      else                                 w_seg = w_glyph;
   end

   // The refresh runs independently of conversions and only reads the committed bcd/overflow.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_div      <= '0;
         r_digitIdx <= 2'd0;
         r_an       <= 4'b1110;
         r_seg      <= 7'b1000000;
      end else if (r_div == DIV_MAX) begin
         r_div      <= '0;
         r_digitIdx <= w_nextIdx;
         r_an       <= w_an;
         r_seg      <= w_seg;
      end else begin
         r_div <= r_div + DIV_W'(1);
      end
   end

   assign bus.o_busy     = w_busy;
   assign bus.o_valid    = r_valid;
   assign bus.o_overflow = r_overflow;
   assign bus.o_bcd      = r_bcd;
   assign bus.o_an       = r_an;
   assign bus.o_seg      = r_seg;
   assign bus.o_dp       = 1'b1;

endmodule

// File: tb/tb_reg_bcd_display.sv
// Self-checking bench for reg_bcd_display: directed and random conversions compared against
// an arithmetic decimal model, plus display slot checks over full refresh frames.
module tb_reg_bcd_display;

   localparam int DIV = 4;

   logic clk = 1'b0;
   logic rst;

   reg_bcd_display_if bus();

   reg_bcd_display #(.REFRESH_DIV(DIV), .BLANK_LZ(1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int checkCount = 0;
   int errorCount = 0;

   // Reference model state: last accepted in-range value and overflow flag.
   int mVal = 0;
   bit mOvf = 1'b0;

   logic [6:0] segTable [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                  7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
      end
   endtask

   function automatic logic [15:0] expBcd();
      if (mOvf) return 16'h9999;
      return {4'(mVal / 1000), 4'((mVal / 100) % 10), 4'((mVal / 10) % 10), 4'(mVal % 10)};
   endfunction

   function automatic logic [6:0] expSeg(input int idx);
      int pow = 1;
      for (int i = 0; i < idx; i++) pow = pow * 10;
      if (mOvf) return 7'b0111111;
      if (idx > 0 && mVal < pow) return 7'b1111111;
      return segTable[(mVal / pow) % 10];
   endfunction

   // Starts a conversion; optionally pulses load at k+3 and k+15, which must be ignored.
   task automatic applyStimulus(input logic [13:0] v, input bit injectIgnored);
      int validAt = 0;
      int validCount = 0;
      @(negedge clk);
      bus.i_load    = 1'b1;
      bus.i_data_in = v;
      @(posedge clk);
      #1;
      bus.i_load = 1'b0;
      checkOutput("busyAfterLoad", 32'(bus.o_busy), 32'd1);
      for (int i = 1; i <= 16; i++) begin
         @(posedge clk);
         #1;
         checkOutput("busy", 32'(bus.o_busy), 32'(i < 15));
         if (bus.o_valid) begin
            validCount++;
            if (validAt == 0) validAt = i;
         end
         if (injectIgnored && (i == 2 || i == 14)) begin
            bus.i_load    = 1'b1;
            bus.i_data_in = 14'd16383;
         end else begin
            bus.i_load = 1'b0;
         end
      end
      bus.i_load = 1'b0;
      checkOutput("validCycle", 32'(validAt), 32'd15);
      checkOutput("validCount", 32'(validCount), 32'd1);
      mOvf = (v > 14'd9999);
      if (!mOvf) mVal = int'(v);
      checkOutput("bcd", 32'(bus.o_bcd), 32'(expBcd()));
      checkOutput("overflow", 32'(bus.o_overflow), 32'(mOvf));
   endtask

   task automatic checkDisplay();
      repeat (4 * DIV) @(posedge clk);
      for (int c = 0; c < 4 * DIV; c++) begin
         int zeros = 0;
         int idx = 0;
         @(posedge clk);
         #1;
         for (int b = 0; b < 4; b++) begin
            if (bus.o_an[b] == 1'b0) begin
               zeros++;
               idx = b;
            end
         end
         checkOutput("anOneHot", 32'(zeros), 32'd1);
         checkOutput("seg", 32'(bus.o_seg), 32'(expSeg(idx)));
      end
      checkOutput("dp", 32'(bus.o_dp), 32'd1);
   endtask

   initial begin
      logic [3:0] expAn;
      logic [6:0] expSg;
      int validSeen;
      logic [13:0] v;

      rst           = 1'b1;
      bus.i_load    = 1'b0;
      bus.i_data_in = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      checkOutput("rstBusy", 32'(bus.o_busy), 32'd0);
      checkOutput("rstValid", 32'(bus.o_valid), 32'd0);
      checkOutput("rstOverflow", 32'(bus.o_overflow), 32'd0);
      checkOutput("rstBcd", 32'(bus.o_bcd), 32'd0);
      checkOutput("rstAn", 32'(bus.o_an), 32'b1110);
      checkOutput("rstSeg", 32'(bus.o_seg), 32'b1000000);
      checkOutput("rstDp", 32'(bus.o_dp), 32'd1);

      for (int c = 1; c <= 12; c++) begin
         @(posedge clk);
         #1;
         expAn = ~(4'b0001 << ((c / DIV) % 4));
         expSg = (((c / DIV) % 4) == 0) ? 7'b1000000 : 7'b1111111;
         checkOutput("anStep", 32'(bus.o_an), 32'(expAn));
         checkOutput("segIdle", 32'(bus.o_seg), 32'(expSg));
      end

      applyStimulus(14'd1234, 1'b0);
      checkDisplay();
      applyStimulus(14'd9999, 1'b0);
      applyStimulus(14'd10000, 1'b0);
      checkDisplay();
      applyStimulus(14'd0, 1'b0);
      checkDisplay();
      applyStimulus(14'd7, 1'b1);
      checkDisplay();

      // Reset in the middle of a conversion must discard it without a valid pulse.
      @(negedge clk);
      bus.i_load    = 1'b1;
      bus.i_data_in = 14'd5678;
      @(posedge clk);
      #1;
      bus.i_load = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      mVal = 0;
      mOvf = 1'b0;
      checkOutput("midRstBusy", 32'(bus.o_busy), 32'd0);
      checkOutput("midRstBcd", 32'(bus.o_bcd), 32'd0);
      checkOutput("midRstAn", 32'(bus.o_an), 32'b1110);
      validSeen = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         if (bus.o_valid) validSeen++;
      end
      checkOutput("midRstNoValid", 32'(validSeen), 32'd0);
      checkOutput("midRstBcdAfter", 32'(bus.o_bcd), 32'd0);
      applyStimulus(14'd5678, 1'b0);
      checkDisplay();
      applyStimulus(14'd1000, 1'b0);
      checkDisplay();

      for (int n = 0; n < 10; n++) begin
         if ($urandom_range(0, 3) == 0) v = 14'($urandom_range(0, 16383));
         else                           v = 14'($urandom_range(0, 9999));
         applyStimulus(v, 1'b0);
         checkDisplay();
      end

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
